// File: rtl/core_div_pkg.sv
// Shared definitions for the EX-stage iterative divider: operation and
// state encodings, datapath width, iteration count and a negate helper.
package core_div_pkg;

    localparam int XLEN     = 32;
    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_e;

    // Two's-complement negate when the flag is set.
    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quot} left, trial-subtract the
// divisor, keep the difference and set the quotient LSB when it is >= 0.
module div_step
    import core_div_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quot_next
);

    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] trial;
    logic            fits;

    // Trial subtraction; one guard bit beyond the 33-bit shifted remainder keeps the sign.
    always_comb begin
        rem_sh    = {rem, quot[XLEN-1]};
        trial     = {1'b0, rem_sh} - {2'b00, divisor};
        fits      = ~trial[XLEN+1];
        rem_next  = fits ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
        quot_next = {quot[XLEN-2:0], fits};
    end

endmodule

// File: rtl/ex_div_unit.sv
// EX-stage radix-2 RV32M divider (DIV/DIVU/REM/REMU) writing the register
// file directly. 33-cycle latency; busy_o stalls the pipeline.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow
// complete straight from IDLE with a precomputed result (latency 1).
module ex_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      waddr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic [4:0]      reg_waddr_o,
    output logic [XLEN-1:0] reg_wdata_o,
    output logic            reg_wen_o
);

    import core_div_pkg::*;

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    div_op_e         op_q;
    logic [4:0]      waddr_q;
    logic [XLEN-1:0] rem_q, quot_q, divisor_q;
    logic            qneg_q, rneg_q;
    logic            wen_q;

    logic            accept;
    logic            signed_op, a_neg, b_neg, div_zero;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] rem_nx, quot_nx;
    logic [XLEN-1:0] final_res;
    logic            last_iter;

    div_step u_step (
        .rem       (rem_q),
        .quot      (quot_q),
        .divisor   (divisor_q),
        .rem_next  (rem_nx),
        .quot_next (quot_nx)
    );

    // Operand conditioning at issue: magnitudes and result sign flags.
    always_comb begin
        accept    = (state_q == IDLE) && start_i && !flush_i;
        signed_op = ~op_i[0];
        a_neg     = signed_op & dividend_i[XLEN-1];
        b_neg     = signed_op & divisor_i[XLEN-1];
        a_abs     = a_neg ? (~dividend_i + 1'b1) : dividend_i;
        b_abs     = b_neg ? (~divisor_i + 1'b1) : divisor_i;
        div_zero  = (divisor_i == '0);
    end

`ifdef DIV_FAST_SPECIAL_EN
    logic ovf;
    // Early-out detection of RISC-V special cases at issue.
    always_comb begin
        ovf         = signed_op && (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) && (divisor_i == '1);
        special     = div_zero | ovf;
        special_res = '0;
        if (div_zero)
            special_res = op_i[1] ? dividend_i : '1;
        else if (ovf)
            special_res = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
`else
    // No early-out: special cases flow through the iterative path.
    always_comb begin
        special     = 1'b0;
        special_res = '0;
    end
`endif

    // Sign-corrected result taken from the final iteration's step output.
    always_comb begin
        last_iter = (cnt_q == CNT_W'(DIV_ITER - 1));
        if (op_q == DIV_OP_REM || op_q == DIV_OP_REMU)
            final_res = neg_if(rem_nx, rneg_q);
        else
            final_res = neg_if(quot_nx, qneg_q);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic and stall output; flush always wins.
    always_comb begin
        state_d = state_q;
        busy_o  = (state_q != IDLE);
        case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : CALC;
            CALC:    if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i)
            state_d = IDLE;
    end

    // Datapath registers and registered write-port values (zero outside DONE).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            op_q        <= DIV_OP_DIV;
            waddr_q     <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            divisor_q   <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            wen_q       <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
        end else begin
            wen_q       <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q      <= div_op_e'(op_i);
                        waddr_q   <= waddr_i;
                        rem_q     <= '0;
                        quot_q    <= a_abs;
                        divisor_q <= b_abs;
                        // Divide-by-zero must yield all-ones regardless of dividend sign.
                        qneg_q    <= (a_neg ^ b_neg) & ~div_zero;
                        rneg_q    <= a_neg;
                        cnt_q     <= '0;
                        if (special) begin
                            wen_q       <= (waddr_i != '0);
                            reg_waddr_o <= waddr_i;
                            reg_wdata_o <= special_res;
                        end
                    end
                end
                CALC: begin
                    rem_q  <= rem_nx;
                    quot_q <= quot_nx;
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_iter && !flush_i) begin
                        wen_q       <= (waddr_q != '0);
                        reg_waddr_o <= waddr_q;
                        reg_wdata_o <= final_res;
                    end
                end
                default: ;
            endcase
        end
    end

    // A flush arriving during DONE cancels the pending write.
    always_comb begin
        reg_wen_o = wen_q & ~flush_i;
    end

endmodule
